// File: rtl/led_bank_scheduler.sv
// led_bank_scheduler
//   Drives the three patch RGB LEDs and the MI indicator LED. The patch
//   stream latches colours into slots 0..2 in order. Each accepted patch
//   produces a one-cycle acknowledge. A re-arm gap of GAP_CYC zero cycles
//   must pass before the next patch is accepted. While done is high the
//   bank blinks green. The MI alert holds rgb_mi yellow for MI_HOLD_CYC
//   cycles from each rising edge of mi_req.
//   Optional build macro: LED_LAMP_TEST_EN. When it is defined, a red/green/
//   blue lamp test runs on every LED after reset, and then the bank arms.
module led_bank_scheduler #(
    parameter int MI_HOLD_CYC    = 2000000,
    parameter int BLINK_HALF_CYC = 1000000,
    parameter int GAP_CYC        = 50000,
    parameter int LAMP_CYC       = 500000
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic [1:0] patch_color,
    input  logic       done,
    input  logic       mi_req,
    output logic       sense_en,
    output logic       patch_ack,
    output logic [1:0] slot_idx,
    output logic [2:0] rgb1,
    output logic [2:0] rgb2,
    output logic [2:0] rgb3,
    output logic [2:0] rgb_mi
);

    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b011;

    localparam int MW = $clog2(MI_HOLD_CYC + 1);
    localparam int BW = $clog2(BLINK_HALF_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [MW-1:0] MI_LOAD    = MW'(MI_HOLD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);

`ifdef LED_LAMP_TEST_EN
    localparam int LW = $clog2(LAMP_CYC + 1);
    localparam logic [LW-1:0] LAMP_LAST = LW'(LAMP_CYC - 1);

    typedef enum logic [1:0] {ARMED, GAP, BLINK, LAMP} state_t;
    localparam state_t RESET_STATE = LAMP;
`else
    typedef enum logic [1:0] {ARMED, GAP, BLINK} state_t;
    localparam state_t RESET_STATE = ARMED;
`endif

    // Every timed phase must last at least one cycle. Otherwise the
    // "parameter minus one" terminal counts would wrap around.
    if (MI_HOLD_CYC < 1 || BLINK_HALF_CYC < 1 || GAP_CYC < 1 || LAMP_CYC < 1) begin : g_bad_param
        $error("led_bank_scheduler: all cycle parameters must be >= 1");
    end

    function automatic logic [2:0] colour_map(input logic [1:0] c);
        case (c)
            2'd1:    colour_map = 3'b001;
            2'd2:    colour_map = 3'b010;
            2'd3:    colour_map = 3'b100;
            default: colour_map = 3'b000;
        endcase
    endfunction

    state_t          state_reg;
    logic            sense_en_reg;
    logic            patch_ack_reg;
    logic [1:0]      slot_idx_reg;
    logic [2:0]      rgb_reg [0:2];
    logic [GW-1:0]   gap_cnt_reg;
    logic [BW-1:0]   blink_cnt_reg;
    logic [MW-1:0]   mi_cnt_reg;
    logic            mi_prev_reg;
`ifdef LED_LAMP_TEST_EN
    logic [LW-1:0]   lamp_cnt_reg;
    logic [1:0]      lamp_step_reg;   // 0 = not started, 1..3 = colour code shown
`endif

    // A slot counts as lit when its LED shows any colour. The bank is full when all three slots are lit.
    logic [2:0] slot_lit;
    logic       bank_full;

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        assign slot_lit[gi] = |rgb_reg[gi];
    end
    assign bank_full = &slot_lit;

    wire mi_rise = mi_req & ~mi_prev_reg;

    // Main scheduler FSM: patch latching, re-arm gap, done blink and lamp test.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_STATE;
            sense_en_reg  <= 1'b0;
            patch_ack_reg <= 1'b0;
            slot_idx_reg  <= 2'd0;
            for (int i = 0; i < 3; i++) rgb_reg[i] <= 3'b000;
            gap_cnt_reg   <= '0;
            blink_cnt_reg <= '0;
`ifdef LED_LAMP_TEST_EN
            lamp_cnt_reg  <= '0;
            lamp_step_reg <= 2'd0;
`endif
        end else begin
            patch_ack_reg <= 1'b0;
            case (state_reg)
                ARMED, GAP: begin
                    sense_en_reg <= 1'b1;
                    if (done) begin
                        // done beats a same-cycle patch. The blink starts green on the next cycle.
                        state_reg     <= BLINK;
                        sense_en_reg  <= 1'b0;
                        blink_cnt_reg <= '0;
                        for (int i = 0; i < 3; i++) rgb_reg[i] <= GREEN;
                    end else if (state_reg == ARMED) begin
                        if (patch_color != 2'd0) begin
                            patch_ack_reg <= 1'b1;
                            state_reg     <= GAP;
                            gap_cnt_reg   <= '0;
                            case (slot_idx_reg)
                                2'd0: begin
                                    rgb_reg[0] <= colour_map(patch_color);
                                    // A refill of slot 0 into a full bank starts a fresh set.
                                    if (bank_full) begin
                                        rgb_reg[1] <= 3'b000;
                                        rgb_reg[2] <= 3'b000;
                                    end
                                    slot_idx_reg <= 2'd1;
                                end
                                2'd1: begin
                                    rgb_reg[1]   <= colour_map(patch_color);
                                    slot_idx_reg <= 2'd2;
                                end
                                default: begin
                                    rgb_reg[2]   <= colour_map(patch_color);
                                    slot_idx_reg <= 2'd0;
                                end
                            endcase
                        end
                    end else begin
                        // GAP: only an unbroken run of zero colours re-arms the sensor.
                        if (patch_color != 2'd0) begin
                            gap_cnt_reg <= '0;
                        end else if (gap_cnt_reg == GAP_LAST) begin
                            gap_cnt_reg <= '0;
                            state_reg   <= ARMED;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                    end
                end

                BLINK: begin
                    if (!done) begin
                        state_reg     <= ARMED;
                        sense_en_reg  <= 1'b1;
                        slot_idx_reg  <= 2'd0;
                        gap_cnt_reg   <= '0;
                        blink_cnt_reg <= '0;
                        for (int i = 0; i < 3; i++) rgb_reg[i] <= 3'b000;
                    end else if (blink_cnt_reg == BLINK_LAST) begin
                        blink_cnt_reg <= '0;
                        for (int i = 0; i < 3; i++) rgb_reg[i] <= rgb_reg[i] ^ GREEN;
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg + 1'b1;
                    end
                end

`ifdef LED_LAMP_TEST_EN
                LAMP: begin
                    sense_en_reg <= 1'b0;
                    if (lamp_step_reg == 2'd0) begin
                        lamp_step_reg <= 2'd1;
                        lamp_cnt_reg  <= '0;
                        for (int i = 0; i < 3; i++) rgb_reg[i] <= colour_map(2'd1);
                    end else if (lamp_cnt_reg == LAMP_LAST) begin
                        lamp_cnt_reg <= '0;
                        if (lamp_step_reg == 2'd3) begin
                            state_reg     <= ARMED;
                            sense_en_reg  <= 1'b1;
                            lamp_step_reg <= 2'd0;
                            for (int i = 0; i < 3; i++) rgb_reg[i] <= 3'b000;
                        end else begin
                            lamp_step_reg <= lamp_step_reg + 1'b1;
                            for (int i = 0; i < 3; i++) rgb_reg[i] <= colour_map(lamp_step_reg + 1'b1);
                        end
                    end else begin
                        lamp_cnt_reg <= lamp_cnt_reg + 1'b1;
                    end
                end
`endif

                default: state_reg <= ARMED;
            endcase
        end
    end

    // MI alert timer: a rising edge of mi_req (re)loads the hold count, and the count then runs down to zero.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            mi_prev_reg <= 1'b0;
            mi_cnt_reg  <= '0;
        end else begin
            mi_prev_reg <= mi_req;
            if (mi_rise) begin
                mi_cnt_reg <= MI_LOAD;
            end else if (mi_cnt_reg != '0) begin
                mi_cnt_reg <= mi_cnt_reg - 1'b1;
            end
        end
    end

    assign sense_en  = sense_en_reg;
    assign patch_ack = patch_ack_reg;
    assign slot_idx  = slot_idx_reg;
    assign rgb1      = rgb_reg[0];
    assign rgb2      = rgb_reg[1];
    assign rgb3      = rgb_reg[2];

`ifdef LED_LAMP_TEST_EN
    // While the lamp test runs, the MI LED mirrors the lamp colour unless an alert is active.
    assign rgb_mi = (mi_cnt_reg != '0) ? YELLOW :
                    ((state_reg == LAMP) ? rgb_reg[0] : 3'b000);
`else
    assign rgb_mi = (mi_cnt_reg != '0) ? YELLOW : 3'b000;
`endif

endmodule
